// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: port A (pipeline WB) has priority, port B feeds a
// DEPTH-entry FIFO whose entries are killed by newer A writes. Optional macro WB_ARBITER_FWD_EN.
module wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       a_valid,
   input  logic [4:0]                 a_reg,
   input  logic [31:0]                a_data,
   input  logic                       b_valid,
   input  logic [4:0]                 b_reg,
   input  logic [31:0]                b_data,
   output logic                       b_ready,
   output logic                       reg_write,
   output logic [4:0]                 write_reg,
   output logic [31:0]                write_data,
   output logic [$clog2(DEPTH):0]     q_count,
   input  logic [4:0]                 chk_reg,
   output logic                       chk_pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [PW-1:0]    rd_ptr_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [CW-1:0]    q_count_r;
   logic [4:0]       q_reg_r  [DEPTH];
   logic [31:0]      q_data_r [DEPTH];
   logic [DEPTH-1:0] q_live_r;

   logic             reg_write_r;
   logic [4:0]       write_reg_r;
   logic [31:0]      write_data_r;

   logic             a_live_s;
   logic             b_ready_s;
   logic             push_s;
   logic             pop_s;
   logic             issue_q_s;
   logic [DEPTH-1:0] kill_s;
   logic [DEPTH-1:0] live_nxt_s;

   // Arbitration decode: A wins, otherwise the head (live or dead) is popped.
   always_comb begin
      a_live_s  = a_valid & (a_reg != 5'd0);
      b_ready_s = (q_count_r < CNT_FULL);
      push_s    = b_valid & b_ready_s & (b_reg != 5'd0);
      pop_s     = ~a_live_s & (q_count_r != {CW{1'b0}});
      issue_q_s = pop_s & q_live_r[rd_ptr_r];
   end

   // Live-bit update: A kills older matches, pop frees the head, push wins last
   // so a B entry enqueued alongside a same-reg A write stays live.
   always_comb begin
      kill_s     = {DEPTH{1'b0}};
      live_nxt_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         kill_s[i]     = a_live_s & (q_reg_r[i] == a_reg);
         live_nxt_s[i] = (q_live_r[i] & ~kill_s[i] & ~(pop_s & (rd_ptr_r == PW'(i))))
                       | (push_s & (wr_ptr_r == PW'(i)));
      end
   end

   // Queue storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r  <= {PW{1'b0}};
         wr_ptr_r  <= {PW{1'b0}};
         q_count_r <= {CW{1'b0}};
         q_live_r  <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            q_reg_r[i]  <= 5'd0;
            q_data_r[i] <= 32'd0;
         end
      end else begin
         q_live_r <= live_nxt_s;
         if (push_s) begin
            q_reg_r[wr_ptr_r]  <= b_reg;
            q_data_r[wr_ptr_r] <= b_data;
            wr_ptr_r           <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   q_count_r <= q_count_r + CNT_ONE;
            2'b01:   q_count_r <= q_count_r - CNT_ONE;
            default: q_count_r <= q_count_r;
         endcase
      end
   end

   // Register-file write port; reg/data hold through idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_r  <= 1'b0;
         write_reg_r  <= 5'd0;
         write_data_r <= 32'd0;
      end else begin
         reg_write_r <= a_live_s | issue_q_s;
         if (a_live_s) begin
            write_reg_r  <= a_reg;
            write_data_r <= a_data;
         end else if (issue_q_s) begin
            write_reg_r  <= q_reg_r[rd_ptr_r];
            write_data_r <= q_data_r[rd_ptr_r];
         end else begin
            write_reg_r  <= write_reg_r;
            write_data_r <= write_data_r;
         end
      end
   end

   assign b_ready    = b_ready_s;
   assign reg_write  = reg_write_r;
   assign write_reg  = write_reg_r;
   assign write_data = write_data_r;
   assign q_count    = q_count_r;

`ifdef WB_ARBITER_FWD_EN
   logic hit_s;
   logic chk_pending_s;

   // Hazard lookup over live queue entries plus the write currently on the port.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_s = hit_s | (q_live_r[i] & (q_reg_r[i] == chk_reg));
      end
      chk_pending_s = (chk_reg != 5'd0)
                    & (hit_s | (reg_write_r & (write_reg_r == chk_reg)));
   end

   assign chk_pending = chk_pending_s;
`else
   logic unused_chk_s;

   assign unused_chk_s = ^chk_reg;
   assign chk_pending  = 1'b0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the port-B write-queue entry count, a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1, system clock; rising edge active.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have ports a_valid, input, 1; a_reg, input, 5; a_data, input, 32: the priority writeback request from the pipeline WB stage, with no ready signal.
REQ-005 The block SHALL have ports b_valid, input, 1; b_reg, input, 5; b_data, input, 32: the late writeback request from the multicycle/load path.
REQ-006 The block SHALL have port b_ready, output, 1, asserted when the port-B queue can accept an entry this cycle.
REQ-007 The block SHALL have ports reg_write, output, 1; write_reg, output, 5; write_data, output, 32: the single register-file write port, all driven from flops.
REQ-008 The block SHALL have port q_count, output, log2(DEPTH)+1, the number of occupied queue entries, dead entries included.
REQ-009 The block SHALL have ports chk_reg, input, 5, and chk_pending, output, 1, a hazard lookup that exists only per REQ-026.

Function
REQ-010 The block SHALL accept port A unconditionally whenever a_valid=1.
REQ-011 Port B handshake SHALL complete on b_valid & b_ready, with b_ready = (q_count < DEPTH) evaluated on the pre-edge count; no same-cycle pop credit is given when the queue is full.
REQ-012 The block SHALL return b_ready=1 and complete a port-B handshake targeting register 0, but SHALL NOT enqueue it.
REQ-013 The block SHALL ignore a port-A request targeting register 0; that cycle counts as no A request.
REQ-014 Issue priority per cycle SHALL be: a live A request, then the queue head, then idle.
REQ-015 An issued write SHALL appear on reg_write/write_reg/write_data exactly one clock after acceptance (A) or pop (queue), held for one cycle only.
REQ-016 In an idle cycle the block SHALL drive reg_write to 0; write_reg/write_data hold their previous values.
REQ-017 The queue SHALL be FIFO with wrapping read/write pointers; a simultaneous push and pop SHALL leave q_count unchanged.
REQ-018 Each queue entry SHALL carry a live bit, set on enqueue.
REQ-019 When an A write to register r issues, the block SHALL clear the live bit of every entry already queued with reg r (kill: A data is newer).
REQ-020 A B entry enqueued in the same cycle as an A write to the same reg SHALL stay live (B is younger).
REQ-021 A dead head SHALL be popped in a cycle with no live A, with reg_write=0 in the following cycle; it is never issued.
REQ-022 The block SHALL NOT pop the queue in any cycle where A issues.

Reset
REQ-023 On rst=1 the block SHALL, asynchronously, clear reg_write, write_reg, write_data, q_count, the pointers and all live bits to 0.
REQ-024 rst asserted mid-operation SHALL discard all queued entries without issuing them.
REQ-025 During rst, b_ready SHALL be 1, but no enqueue SHALL occur until the first edge after rst deasserts.

Configuration
REQ-026 With macro WB_ARBITER_FWD_EN defined, chk_pending SHALL be combinationally 1 iff chk_reg is nonzero and matches a live queued entry or the in-flight output write (reg_write=1).
REQ-027 With WB_ARBITER_FWD_EN undefined, chk_pending SHALL be tied 0 and the per-entry compare logic SHALL be absent.

Verification
REQ-028 The bench SHALL cover: A only, a_reg=5, a_data=0x11 -> next cycle reg_write=1, write_reg=5, write_data=0x11; following cycle reg_write=0.
REQ-029 The bench SHALL cover: B pushes reg 3/0xA, 4/0xB, 6/0xC, 7/0xD while a_valid=1 every cycle -> b_ready=0 with q_count=4; once A stops, the writes issue in order 3,4,6,7 on consecutive cycles.
REQ-030 The bench SHALL cover: queue holds reg 9/0x1, then A writes 9/0x2 -> write 9=0x2 issues, the dead entry pops with reg_write=0, and 0x1 is never written.
REQ-031 The bench SHALL cover: A reg=0 with B reg=0 -> no write issues, q_count stays 0, b_ready=1.
REQ-032 The bench SHALL cover: 3 entries queued, rst pulsed mid-cycle -> outputs and q_count read 0 immediately, and no queued write ever issues.
REQ-033 The bench SHALL cover, with WB_ARBITER_FWD_EN: queue holds reg 12, chk_reg=12 -> chk_pending=1; chk_reg=13 -> 0; after reg 12 retires -> 0.
